alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational 32-bit ALU between two requesters: req0 is the execute stage and req1 is the address/branch unit.
- Arbitrates between them round-robin and registers the winning operands onto the ALU inputs for one EXEC cycle.
- Captures the ALU result and returns it on a single tagged response channel.
- Owns the architectural flag register {sf,zf,cf,vf}, which updates only when the ALU asserts flag_up.

Parameters:
RR_INIT, 0, requester favoured first after reset (0 or 1).
FLAG_RST, 4'b0000, reset value of the flag register {sf,zf,cf,vf}.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-high.
req0_valid  input  1  requester 0 has an op.
req0_ready  output  1  op on requester 0 accepted this cycle.
req0_ir / req0_sr / req0_tr  input  32 each  instruction word, rg1, rg2 from requester 0.
req1_valid, req1_ready, req1_ir, req1_sr, req1_tr  same as requester 0, for requester 1.
alu_ir / alu_sr / alu_tr  output  32 each  registered operands driving the ALU.
alu_dr  input  32  ALU result.
alu_sf, alu_zf, alu_cf, alu_vf, alu_flag_up  input  1 each  ALU flag outputs.
rsp_valid  output  1  response available.
rsp_ready  input  1  consumer takes response.
rsp_id  output  1  requester that owns the response.
rsp_dr  output  32  captured result.
rsp_flag_up  output  1  op updated flags.
flags  output  4  flag register {sf,zf,cf,vf}.
busy  output  1  state != IDLE.

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high (rst). All state updates on the rising edge of clk.
- States are IDLE, EXEC and RESP.
- IDLE:
  - Grant is combinational from the valids.
  - Only one valid: grant it.
  - Both valid: grant the requester pointed to by rr_ptr.
  - reqN_ready=1 only for the granted requester, and only in IDLE. req0_ready and req1_ready are never both 1.
  - On handshake (valid&ready): latch ir/sr/tr into alu_*, latch id, set rr_ptr = ~id, go to EXEC.
- EXEC (exactly 1 cycle):
  - ALU evaluates the registered operands.
  - At cycle end: rsp_dr<=alu_dr, rsp_flag_up<=alu_flag_up.
  - If alu_flag_up, flags<={alu_sf,alu_zf,alu_cf,alu_vf}; otherwise flags hold.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_dr, rsp_flag_up held stable until handshake.
  - On rsp_ready: go to IDLE. rsp_ready=0 stalls indefinitely with the outputs stable.
- Latency: accepted in cycle N, EXEC in N+1, rsp_valid first high in N+2. Minimum issue interval is 3 cycles.
- Flags visible on the flags output from N+2, coincident with rsp_valid.
- rr_ptr changes only on a grant. A lone valid requester never starves, and with both requesters continuously valid, grants strictly alternate.
- alu_* hold their last value outside EXEC. The ALU is combinational, so this has no side effects.
- A requester may drop valid before it is granted. No commitment is implied until ready.
- Reset values (including reset mid-EXEC or mid-RESP, where the in-flight op is discarded and no response is issued):
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_dr=0, rsp_flag_up=0
  - alu_ir/sr/tr=0, flags=FLAG_RST, rr_ptr=RR_INIT, busy=0
  - reqN_ready is still gated by valid in the cycle after reset.
- Response consumed in the same cycle as a new request arrives: the request is not accepted until the following IDLE cycle (no RESP→EXEC bypass).

Optional Feature:
ALU_ARB_FIXED_PRIO_EN:
- Defined: req0 always wins when both are valid. rr_ptr is removed, RR_INIT is ignored, and req1 can starve.
- Undefined: round-robin as above.

Test Plan:
1. Reset, then req0 ADD with tr=5, sr=3 → req0_ready in cycle N, rsp_valid at N+2, rsp_id=0, rsp_dr=8, rsp_flag_up=1, flags=4'b0000.
2. req1 CMP with tr=3, sr=3 → rsp_dr=0, flags zf=1, cf=0. Then req0 LD (flag_up=0) → flags unchanged.
3. Both valid continuously for 6 ops with RR_INIT=0 → grant order 0,1,0,1,0,1. With ALU_ARB_FIXED_PRIO_EN → 0,0,0,0,0,0.
4. rsp_ready held 0 for 5 cycles after rsp_valid → rsp_* stable, both reqN_ready=0, busy=1. Release → IDLE next cycle, new grant the cycle after.
5. Assert rst during EXEC of an ADD that would set cf → no response, flags=FLAG_RST, state IDLE, rr_ptr=RR_INIT.
6. req1 alone SUB with tr=0, sr=1 → rsp_dr=32'hFFFFFFFF, sf=1, cf=1. Next, both valid → req0 granted (rr_ptr=0 after req1's grant).

Source files
------------

// File: rtl/alu_arbiter.sv
// Shares one combinational 32-bit ALU between two requesters and owns the {sf,zf,cf,vf} flag register.
// Optional macro ALU_ARB_FIXED_PRIO_EN: req0 always wins ties (no round-robin pointer).
module alu_arbiter #(
    parameter logic       RR_INIT  = 1'b0,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_ir,
    input  logic [31:0] req0_sr,
    input  logic [31:0] req0_tr,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_ir,
    input  logic [31:0] req1_sr,
    input  logic [31:0] req1_tr,
    output logic [31:0] alu_ir,
    output logic [31:0] alu_sr,
    output logic [31:0] alu_tr,
    input  logic [31:0] alu_dr,
    input  logic        alu_sf,
    input  logic        alu_zf,
    input  logic        alu_cf,
    input  logic        alu_vf,
    input  logic        alu_flag_up,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_dr,
    output logic        rsp_flag_up,
    output logic [3:0]  flags,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   grant_any;
    logic   grant_id;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic   rr_ptr;
`endif

    // Grant selection: a lone valid always wins; ties go to the pointer (or req0 when fixed).
    always_comb begin
        grant_any = req0_valid | req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant_id  = ~req0_valid;
`else
        grant_id  = (req0_valid & req1_valid) ? rr_ptr : ~req0_valid;
`endif
    end

    assign req0_ready = (state == IDLE) & req0_valid & ~grant_id;
    assign req1_ready = (state == IDLE) & req1_valid & grant_id;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_dr      <= 32'd0;
            rsp_flag_up <= 1'b0;
            alu_ir      <= 32'd0;
            alu_sr      <= 32'd0;
            alu_tr      <= 32'd0;
            flags       <= FLAG_RST;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr      <= RR_INIT;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        alu_ir <= grant_id ? req1_ir : req0_ir;
                        alu_sr <= grant_id ? req1_sr : req0_sr;
                        alu_tr <= grant_id ? req1_tr : req0_tr;
                        rsp_id <= grant_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        rr_ptr <= ~grant_id;
`endif
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_dr      <= alu_dr;
                    rsp_flag_up <= alu_flag_up;
                    if (alu_flag_up) begin
                        flags <= {alu_sf, alu_zf, alu_cf, alu_vf};
                    end
                    rsp_valid   <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    // Return to IDLE only; a new grant waits for the next IDLE cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model. Honours ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;

    localparam logic       RR_INIT  = 1'b0;
    localparam logic [3:0] FLAG_RST = 4'b0101;
    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_SUB   = 2'd1;
    localparam logic [1:0] OP_CMP   = 2'd2;
    localparam logic [1:0] OP_LD    = 2'd3;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_ir, req0_sr, req0_tr, req1_ir, req1_sr, req1_tr;
    logic [31:0] alu_ir, alu_sr, alu_tr, alu_dr;
    logic        alu_sf, alu_zf, alu_cf, alu_vf, alu_flag_up;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_flag_up, busy;
    logic [31:0] rsp_dr;
    logic [3:0]  flags;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        fu;
        logic [3:0]  fl;
        logic [31:0] dr;
    } alu_res_t;

    alu_arbiter #(.RR_INIT(RR_INIT), .FLAG_RST(FLAG_RST)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_ir(req0_ir), .req0_sr(req0_sr), .req0_tr(req0_tr),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_ir(req1_ir), .req1_sr(req1_sr), .req1_tr(req1_tr),
        .alu_ir(alu_ir), .alu_sr(alu_sr), .alu_tr(alu_tr), .alu_dr(alu_dr),
        .alu_sf(alu_sf), .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_vf(alu_vf),
        .alu_flag_up(alu_flag_up),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_dr(rsp_dr), .rsp_flag_up(rsp_flag_up), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    // Small ALU: opcode in ir[1:0]; ADD/SUB/CMP update flags, LD passes sr without touching them.
    function automatic alu_res_t alu_eval(input logic [31:0] ir, input logic [31:0] sr,
                                          input logic [31:0] tr);
        alu_res_t    r;
        logic [32:0] wide;
        r    = '0;
        wide = {1'b0, tr} + {1'b0, sr};
        case (ir[1:0])
            OP_ADD: begin
                r.dr    = wide[31:0];
                r.fl[1] = wide[32];
                r.fl[0] = (tr[31] == sr[31]) && (r.dr[31] != tr[31]);
                r.fu    = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                r.dr    = tr - sr;
                r.fl[1] = (tr < sr);
                r.fl[0] = (tr[31] != sr[31]) && (r.dr[31] != tr[31]);
                r.fu    = 1'b1;
            end
            default: begin
                r.dr = sr;
                r.fu = 1'b0;
            end
        endcase
        r.fl[3] = r.dr[31];
        r.fl[2] = (r.dr == 32'd0);
        return r;
    endfunction

    alu_res_t env;
    always_comb env = alu_eval(alu_ir, alu_sr, alu_tr);
    assign alu_dr      = env.dr;
    assign alu_flag_up = env.fu;
    assign {alu_sf, alu_zf, alu_cf, alu_vf} = env.fl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Transaction model: stage counts cycles since acceptance (0 waiting, 1 executing, 2 responding).
    int          m_stage = 0;
    bit          m_known = 1'b0;
    logic        m_ptr, m_id;
    logic [3:0]  m_flags;
    logic [31:0] m_ir, m_sr, m_tr;
    alu_res_t    m_res;

    always @(negedge clk) begin
        logic any, both, g;
        any  = req0_valid | req1_valid;
        both = req0_valid & req1_valid;
        g    = both ? (FIXED ? 1'b0 : m_ptr) : ~req0_valid;
        if (m_known) begin
            chk("req0_ready", 32'(req0_ready), 32'(m_stage == 0 && any && !g));
            chk("req1_ready", 32'(req1_ready), 32'(m_stage == 0 && any && g));
            chk("busy", 32'(busy), 32'(m_stage != 0));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_stage == 2));
            chk("flags", 32'(flags), 32'(m_flags));
            chk("alu_ir", alu_ir, m_ir);
            chk("alu_sr", alu_sr, m_sr);
            chk("alu_tr", alu_tr, m_tr);
            if (m_stage == 2) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_dr", rsp_dr, m_res.dr);
                chk("rsp_flag_up", 32'(rsp_flag_up), 32'(m_res.fu));
            end
        end
        if (rst) begin
            m_known = 1'b1;
            m_stage = 0;
            m_ptr   = RR_INIT;
            m_flags = FLAG_RST;
            m_ir    = 32'd0;
            m_sr    = 32'd0;
            m_tr    = 32'd0;
        end else if (m_known) begin
            if (m_stage == 0 && any) begin
                m_id    = g;
                m_ptr   = ~g;
                m_ir    = g ? req1_ir : req0_ir;
                m_sr    = g ? req1_sr : req0_sr;
                m_tr    = g ? req1_tr : req0_tr;
                m_stage = 1;
            end else if (m_stage == 1) begin
                m_res = alu_eval(m_ir, m_sr, m_tr);
                if (m_res.fu) m_flags = m_res.fl;
                m_stage = 2;
            end else if (m_stage == 2 && rsp_ready) begin
                m_stage = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op, wait (bounded) for its grant, then withdraw valid after the accepting edge.
    task automatic issue(input logic who, input logic [31:0] ir, input logic [31:0] sr,
                         input logic [31:0] tr);
        int n;
        tick();
        if (who) begin
            req1_valid = 1'b1; req1_ir = ir; req1_sr = sr; req1_tr = tr;
        end else begin
            req0_valid = 1'b1; req0_ir = ir; req0_sr = sr; req0_tr = tr;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(who ? req1_ready : req0_ready) && n < 20);
        chk("grant_wait", 32'(who ? req1_ready : req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        chk("rsp_wait", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        int         lat;
        int         n;
        logic [5:0] exp_order;
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_ir = '0; req0_sr = '0; req0_tr = '0;
        req1_valid = 1'b0; req1_ir = '0; req1_sr = '0; req1_tr = '0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_flags", 32'(flags), 32'(FLAG_RST));
        chk("rst_alu_ir", alu_ir, 32'd0);
        chk("rst_rsp_dr", rsp_dr, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_flag_up", 32'(rsp_flag_up), 32'd0);

        // ADD 5+3 from req0
        issue(1'b0, {30'h1234, OP_ADD}, 32'd3, 32'd5);
        wait_rsp(lat);
        chk("add_latency", 32'(lat), 32'd2);
        chk("add_id", 32'(rsp_id), 32'd0);
        chk("add_dr", rsp_dr, 32'd8);
        chk("add_fu", 32'(rsp_flag_up), 32'd1);
        chk("add_flags", 32'(flags), 32'b0000);

        // CMP 3,3 from req1, then LD leaves flags alone
        issue(1'b1, {30'h0, OP_CMP}, 32'd3, 32'd3);
        wait_rsp(lat);
        chk("cmp_id", 32'(rsp_id), 32'd1);
        chk("cmp_dr", rsp_dr, 32'd0);
        chk("cmp_flags", 32'(flags), 32'b0100);
        issue(1'b0, {30'h0, OP_LD}, 32'h1234, 32'd9);
        wait_rsp(lat);
        chk("ld_dr", rsp_dr, 32'h1234);
        chk("ld_fu", 32'(rsp_flag_up), 32'd0);
        chk("ld_flags", 32'(flags), 32'b0100);

        // Consumer stall for 5 cycles with req1 waiting
        tick();
        rsp_ready = 1'b0;
        issue(1'b0, {30'h0, OP_ADD}, 32'd7, 32'd9);
        wait_rsp(lat);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                tick();
                if (c == 1) begin
                    req1_valid = 1'b1; req1_ir = {30'h0, OP_SUB}; req1_sr = 32'd4; req1_tr = 32'd10;
                end
                @(negedge clk);
            end
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_dr", rsp_dr, 32'd16);
            chk("stall_id", 32'(rsp_id), 32'd0);
            chk("stall_ready1", 32'(req1_ready), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_busy", 32'(busy), 32'd0);
        chk("release_grant1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        wait_rsp(lat);
        chk("release_lat", 32'(lat), 32'd2);
        chk("release_dr", rsp_dr, 32'd6);
        chk("release_id", 32'(rsp_id), 32'd1);

        // Reset during EXEC of a carrying ADD (req0 grant leaves pointer at 1)
        issue(1'b0, {30'h0, OP_ADD}, 32'd1, 32'hFFFF_FFFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("midrst_busy", 32'(busy), 32'd0);
            chk("midrst_flags", 32'(flags), 32'(FLAG_RST));
        end
        chk("midrst_alu_tr", alu_tr, 32'd0);

        // Both valid continuously for six ops
        exp_order = FIXED ? 6'b000000 : 6'b101010;
        tick();
        req0_valid = 1'b1; req0_ir = {30'h0, OP_ADD}; req0_sr = 32'd1; req0_tr = 32'd2;
        req1_valid = 1'b1; req1_ir = {30'h0, OP_SUB}; req1_sr = 32'd2; req1_tr = 32'd1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(req0_ready | req1_ready) && n < 20);
            chk("order_seen", 32'(req0_ready | req1_ready), 32'd1);
            chk("order_id", 32'(req1_ready), 32'(exp_order[k]));
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(lat);

        // req1 alone SUB 0-1, then a tie must favour req0
        issue(1'b1, {30'h0, OP_SUB}, 32'd1, 32'd0);
        wait_rsp(lat);
        chk("sub_dr", rsp_dr, 32'hFFFF_FFFF);
        chk("sub_id", 32'(rsp_id), 32'd1);
        chk("sub_flags", 32'(flags), 32'b1010);
        tick();
        req0_valid = 1'b1; req0_ir = {30'h0, OP_LD}; req0_sr = 32'd77;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("tie_ready0", 32'(req0_ready), 32'd1);
        chk("tie_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(lat);
        chk("tie_id", 32'(rsp_id), 32'd0);
        chk("tie_dr", rsp_dr, 32'd77);

        // Random traffic with occasional resets, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            tick();
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_ir    = $urandom;
            req1_ir    = $urandom;
            req0_sr    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req0_tr    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req1_sr    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req1_tr    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            rsp_ready  = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 299) == 0);
        end
        tick();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
